shift_reg_univ: RTL and testbench

//   Parametrised universal shift register; next generation of the 2-bit serial shift chain.

---
 rtl/shift_reg_univ_pkg.sv | 14 +
 rtl/shift_reg_univ_if.sv | 30 +++
 rtl/shift_reg_univ_shift_cell.sv | 41 ++++
 rtl/shift_reg_univ.sv | 80 ++++++++
 tb/tb_shift_reg_univ.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/shift_reg_univ_pkg.sv
// Shared definitions for the universal shift register: mode encoding and logic constants.
package shift_reg_univ_pkg;

  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_SHR  = 2'b01,
    SR_SHL  = 2'b10,
    SR_LOAD = 2'b11
  } sr_mode_e;

  localparam logic LOGIC_FALSE = 1'b0;
  localparam logic LOGIC_TRUE  = 1'b1;

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle of the universal shift register; clock and reset stay outside.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             EN;
  logic [1:0]       M;
  logic             SIR;
  logic             SIL;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] Q;
  logic             SOR;
  logic             SOL;
  logic [CNT_W-1:0] CNT;
  logic             DONE;

  // Stimulus side: drives mode/data, observes register state.
  modport master (
    output EN, M, SIR, SIL, P,
    input  Q, SOR, SOL, CNT, DONE
  );

  // Register side.
  modport slave (
    input  EN, M, SIR, SIL, P,
    output Q, SOR, SOL, CNT, DONE
  );

endinterface

// File: rtl/shift_reg_univ_shift_cell.sv
// One register stage: 4:1 mode mux (hold / right neighbour / left neighbour / load) feeding
// a flop with synchronous reset and clock enable.
module shift_cell
  import shift_reg_univ_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       right_nbr_i,  // value moving down on a right shift (Q[i+1] or SIR)
  input  logic       left_nbr_i,   // value moving up on a left shift (Q[i-1] or SIL)
  input  logic       par_i,
  output logic       q_o
);

  logic q_q;
  logic q_d;

  // Next-state select; disabled or hold mode keeps the stored bit.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      case (sr_mode_e'(mode_i))
        SR_HOLD: q_d = q_q;
        SR_SHR:  q_d = right_nbr_i;
        SR_SHL:  q_d = left_nbr_i;
        SR_LOAD: q_d = par_i;
        default: q_d = q_q;
      endcase
    end
  end

  // Stage flop; reset overrides enable and mode.
  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: WIDTH shift_cell stages plus a saturating shift counter whose
// DONE flag marks a full word shifted in or out (serialiser/deserialiser use).
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             C,
  input  logic             R,
  shift_reg_univ_if.slave  sr
);

  if (WIDTH < 2) begin : g_bad_width
    $error("shift_reg_univ: WIDTH must be at least 2");
  end
  if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("shift_reg_univ: CNT_W too small to hold WIDTH");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_w;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // End stages take the serial inputs instead of a neighbour.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic right_nbr;
    logic left_nbr;

    if (i == WIDTH - 1) begin : g_top_end
      assign right_nbr = sr.SIR;
    end else begin : g_top_mid
      assign right_nbr = q_w[i+1];
    end

    if (i == 0) begin : g_bot_end
      assign left_nbr = sr.SIL;
    end else begin : g_bot_mid
      assign left_nbr = q_w[i-1];
    end

    shift_cell u_cell (
      .clk_i       (C),
      .rst_i       (R),
      .en_i        (sr.EN),
      .mode_i      (sr.M),
      .right_nbr_i (right_nbr),
      .left_nbr_i  (left_nbr),
      .par_i       (sr.P[i]),
      .q_o         (q_w[i])
    );
  end

  // Shift count: either direction increments up to WIDTH and then saturates; load clears.
  always_comb begin
    cnt_d = cnt_q;
    if (sr.EN) begin
      case (sr_mode_e'(sr.M))
        SR_SHR, SR_SHL: if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
        SR_LOAD:        cnt_d = '0;
        default:        cnt_d = cnt_q;
      endcase
    end
  end

  // Counter register; reset discards any partial shift sequence.
  always_ff @(posedge C) begin
    if (R) cnt_q <= '0;
    else   cnt_q <= cnt_d;
  end

  assign sr.Q    = q_w;
  assign sr.SOR  = q_w[0];
  assign sr.SOL  = q_w[WIDTH-1];
  assign sr.CNT  = cnt_q;
  assign sr.DONE = (cnt_q == CNT_MAX) ? LOGIC_TRUE : LOGIC_FALSE;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ at WIDTH=4, CNT_W=3: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_shift_reg_univ;

  localparam int W  = 4;
  localparam int CW = 3;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  // Reference model state: register value as an integer and total shift count.
  int unsigned m_q   = 0;
  int unsigned m_cnt = 0;

  shift_reg_univ_if #(.WIDTH(W), .CNT_W(CW)) sr_if ();

  shift_reg_univ #(.WIDTH(W), .CNT_W(CW)) dut (
    .C  (clk),
    .R  (rst),
    .sr (sr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, advance the model at the edge, settle 1 time unit after.
  task automatic step(input logic r, input logic en, input logic [1:0] m,
                      input logic sir, input logic sil, input logic [W-1:0] p);
    rst       = r;
    sr_if.EN  = en;
    sr_if.M   = m;
    sr_if.SIR = sir;
    sr_if.SIL = sil;
    sr_if.P   = p;
    @(posedge clk);
    if (r) begin
      m_q = 0; m_cnt = 0;
    end else if (en) begin
      case (m)
        2'b01: begin
          m_q = (m_q / 2) + (sir ? (1 << (W - 1)) : 0);
          if (m_cnt < W) m_cnt = m_cnt + 1;
        end
        2'b10: begin
          m_q = ((m_q * 2) + (sil ? 1 : 0)) % (1 << W);
          if (m_cnt < W) m_cnt = m_cnt + 1;
        end
        2'b11: begin
          m_q = p; m_cnt = 0;
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 4'b1111);
    checks++; if (sr_if.Q !== 4'b0000) begin errors++; $display("FAIL reset_q: got %b want 0000", sr_if.Q); end
    checks++; if (sr_if.CNT !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", sr_if.CNT); end
    checks++; if (sr_if.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", sr_if.DONE); end
  endtask

  task automatic test_load();
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
    checks++; if (sr_if.Q !== 4'b1011) begin errors++; $display("FAIL load_q: got %b want 1011", sr_if.Q); end
    checks++; if ({sr_if.SOR, sr_if.SOL} !== 2'b11) begin errors++; $display("FAIL load_so: got %b want 11", {sr_if.SOR, sr_if.SOL}); end
    checks++; if (sr_if.CNT !== 3'd0) begin errors++; $display("FAIL load_cnt: got %0d want 0", sr_if.CNT); end
  endtask

  task automatic test_shift_right();
    logic [W-1:0] exp_q [4];
    logic         exp_sor [4];
    exp_q   = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    exp_sor = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      checks++; if (sr_if.SOR !== exp_sor[i]) begin errors++; $display("FAIL shr_sor%0d: got %b want %b", i, sr_if.SOR, exp_sor[i]); end
      step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'b0000);
      checks++; if (sr_if.Q !== exp_q[i]) begin errors++; $display("FAIL shr_q%0d: got %b want %b", i, sr_if.Q, exp_q[i]); end
      checks++; if (sr_if.DONE !== (i == 3)) begin errors++; $display("FAIL shr_done%0d: got %b want %b", i, sr_if.DONE, (i == 3)); end
    end
    checks++; if (sr_if.CNT !== 3'd4) begin errors++; $display("FAIL shr_cnt: got %0d want 4", sr_if.CNT); end
    step(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000);
    checks++; if (sr_if.CNT !== 3'd4) begin errors++; $display("FAIL shr_sat_cnt: got %0d want 4", sr_if.CNT); end
    checks++; if (sr_if.DONE !== 1'b1) begin errors++; $display("FAIL shr_sat_done: got %b want 1", sr_if.DONE); end
    checks++; if (sr_if.Q !== 4'b1000) begin errors++; $display("FAIL shr_sat_q: got %b want 1000", sr_if.Q); end
  endtask

  task automatic test_shift_left();
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'b0000);
    checks++; if (sr_if.Q !== 4'b0001) begin errors++; $display("FAIL shl_q0: got %b want 0001", sr_if.Q); end
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'b0000);
    checks++; if (sr_if.Q !== 4'b0011) begin errors++; $display("FAIL shl_q1: got %b want 0011", sr_if.Q); end
    checks++; if (sr_if.CNT !== 3'd2) begin errors++; $display("FAIL shl_cnt: got %0d want 2", sr_if.CNT); end
    checks++; if (sr_if.DONE !== 1'b0) begin errors++; $display("FAIL shl_done: got %b want 0", sr_if.DONE); end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
    step(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 4'b1111);
    checks++; if (sr_if.Q !== 4'b1011) begin errors++; $display("FAIL hold_en0_q: got %b want 1011", sr_if.Q); end
    checks++; if (sr_if.CNT !== 3'd1) begin errors++; $display("FAIL hold_en0_cnt: got %0d want 1", sr_if.CNT); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'b1111);
    checks++; if (sr_if.Q !== 4'b1011) begin errors++; $display("FAIL hold_m00_q: got %b want 1011", sr_if.Q); end
    checks++; if (sr_if.CNT !== 3'd1) begin errors++; $display("FAIL hold_m00_cnt: got %0d want 1", sr_if.CNT); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1101);
    step(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'b0000);
    checks++; if (sr_if.CNT !== 3'd2) begin errors++; $display("FAIL mid_pre_cnt: got %0d want 2", sr_if.CNT); end
    step(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 4'b1111);
    checks++; if ({sr_if.Q, sr_if.CNT, sr_if.DONE} !== 8'b0000_000_0) begin errors++; $display("FAIL mid_reset: got Q=%b CNT=%0d DONE=%b want Q=0000 CNT=0 DONE=0", sr_if.Q, sr_if.CNT, sr_if.DONE); end
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1001);
    checks++; if (sr_if.Q !== 4'b1001) begin errors++; $display("FAIL mid_reload: got %b want 1001", sr_if.Q); end
  endtask

  task automatic test_random();
    logic [W-1:0]  exp_q;
    logic [CW-1:0] exp_cnt;
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), W'($urandom));
      exp_q   = W'(m_q);
      exp_cnt = CW'(m_cnt);
      checks++;
      if ({sr_if.Q, sr_if.SOR, sr_if.SOL, sr_if.CNT, sr_if.DONE} !==
          {exp_q, exp_q[0], exp_q[W-1], exp_cnt, (m_cnt == W)}) begin
        errors++;
        $display("FAIL rand%0d: got Q=%b SOR=%b SOL=%b CNT=%0d DONE=%b want Q=%b SOR=%b SOL=%b CNT=%0d DONE=%b",
                 i, sr_if.Q, sr_if.SOR, sr_if.SOL, sr_if.CNT, sr_if.DONE,
                 exp_q, exp_q[0], exp_q[W-1], exp_cnt, (m_cnt == W));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sr_if.EN = 1'b0; sr_if.M = 2'b00; sr_if.SIR = 1'b0; sr_if.SIL = 1'b0; sr_if.P = '0;
    test_reset();
    test_load();
    test_shift_right();
    test_shift_left();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
